// File: rtl/ball_obstacle_collision_detector_if.sv
// Pixel-stream inputs and collision report outputs of the ball/obstacle collision detector.
// The obstMask input exists only when COLLISION_MASK_EN is defined.
interface ball_obstacle_collision_detector_if #(
   parameter int N_OBJ = 4
);
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

   logic             startOfFrame;
   logic [10:0]      pixelX;
   logic [10:0]      pixelY;
   logic             ballDR;
   logic [N_OBJ-1:0] obstDR;
`ifdef COLLISION_MASK_EN
   logic [N_OBJ-1:0] obstMask;
`endif
   logic             collision;
   logic [IDX_W-1:0] hitIndex;
   logic [10:0]      hitX;
   logic [10:0]      hitY;
   logic [15:0]      hitPixels;
   logic             holdoff;

   modport master (
      output startOfFrame, pixelX, pixelY, ballDR, obstDR,
`ifdef COLLISION_MASK_EN
      output obstMask,
`endif
      input  collision, hitIndex, hitX, hitY, hitPixels, holdoff
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, ballDR, obstDR,
`ifdef COLLISION_MASK_EN
      input  obstMask,
`endif
      output collision, hitIndex, hitX, hitY, hitPixels, holdoff
   );
endinterface

// File: rtl/ball_obstacle_collision_detector.sv
// Ball/obstacle pixel-overlap detector: one report per frame, with a frame-count hold-off after each report.
// Latency: report registered at the startOfFrame edge. No backpressure. COLLISION_MASK_EN adds per-obstacle masking.
module ball_obstacle_collision_detector #(
   parameter int N_OBJ          = 4,
   parameter int HOLDOFF_FRAMES = 2
) (
   input logic clk,
   input logic resetN,
   ball_obstacle_collision_detector_if.slave bus
);
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

   typedef enum logic [1:0] {SYNC, ARMED, HOLDOFF} state_t;

   state_t           state_q, state_d;
   logic             hit_seen_q, hit_seen_d;
   logic [15:0]      count_q, count_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
   logic [10:0]      cap_x_q, cap_x_d;
   logic [10:0]      cap_y_q, cap_y_d;
   logic             collision_q, collision_d;
   logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
   logic [10:0]      hit_x_q, hit_x_d;
   logic [10:0]      hit_y_q, hit_y_d;
   logic [15:0]      hit_pixels_q, hit_pixels_d;
   logic             holdoff_q, holdoff_d;
   logic [N_OBJ-1:0] overlap_vec;
   logic             overlap;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [N_OBJ-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

`ifdef COLLISION_MASK_EN
   logic [N_OBJ-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = bus.startOfFrame ? bus.obstMask : mask_q;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) mask_q <= '1;
      else         mask_q <= mask_d;
   end

   assign overlap_vec = bus.obstDR & mask_q;
`else
   assign overlap_vec = bus.obstDR;
`endif

   // Frame-boundary cycles never count as overlap.
   assign overlap = bus.ballDR && (overlap_vec != '0) && !bus.startOfFrame && (state_q == ARMED);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_q <= SYNC;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC: begin
            if (bus.startOfFrame) state_d = ARMED;
         end
         ARMED: begin
            if (bus.startOfFrame && hit_seen_q && (HOLDOFF_FRAMES != 0)) state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (bus.startOfFrame && (hold_cnt_q == 4'd1)) state_d = ARMED;
         end
         default: state_d = SYNC;
      endcase
   end

   always_comb begin
      hit_seen_d   = hit_seen_q;
      count_d      = count_q;
      hold_cnt_d   = hold_cnt_q;
      cap_idx_d    = cap_idx_q;
      cap_x_d      = cap_x_q;
      cap_y_d      = cap_y_q;
      collision_d  = 1'b0;
      hit_idx_d    = hit_idx_q;
      hit_x_d      = hit_x_q;
      hit_y_d      = hit_y_q;
      hit_pixels_d = hit_pixels_q;
      case (state_q)
         ARMED: begin
            if (bus.startOfFrame) begin
               if (hit_seen_q) begin
                  collision_d  = 1'b1;
                  hit_idx_d    = cap_idx_q;
                  hit_x_d      = cap_x_q;
                  hit_y_d      = cap_y_q;
                  hit_pixels_d = count_q;
                  hold_cnt_d   = 4'(HOLDOFF_FRAMES);
               end
               hit_seen_d = 1'b0;
               count_d    = '0;
            end else if (overlap) begin
               if (!hit_seen_q) begin
                  hit_seen_d = 1'b1;
                  cap_idx_d  = lowest_set(overlap_vec);
                  cap_x_d    = bus.pixelX;
                  cap_y_d    = bus.pixelY;
               end
               if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            end
         end
         HOLDOFF: begin
            if (bus.startOfFrame) hold_cnt_d = hold_cnt_q - 4'd1;
         end
         default: ;
      endcase
      holdoff_d = (state_d == HOLDOFF);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hit_seen_q   <= 1'b0;
         count_q      <= '0;
         hold_cnt_q   <= '0;
         cap_idx_q    <= '0;
         cap_x_q      <= '0;
         cap_y_q      <= '0;
         collision_q  <= 1'b0;
         hit_idx_q    <= '0;
         hit_x_q      <= '0;
         hit_y_q      <= '0;
         hit_pixels_q <= '0;
         holdoff_q    <= 1'b0;
      end else begin
         hit_seen_q   <= hit_seen_d;
         count_q      <= count_d;
         hold_cnt_q   <= hold_cnt_d;
         cap_idx_q    <= cap_idx_d;
         cap_x_q      <= cap_x_d;
         cap_y_q      <= cap_y_d;
         collision_q  <= collision_d;
         hit_idx_q    <= hit_idx_d;
         hit_x_q      <= hit_x_d;
         hit_y_q      <= hit_y_d;
         hit_pixels_q <= hit_pixels_d;
         holdoff_q    <= holdoff_d;
      end
   end

   assign bus.collision = collision_q;
   assign bus.hitIndex  = hit_idx_q;
   assign bus.hitX      = hit_x_q;
   assign bus.hitY      = hit_y_q;
   assign bus.hitPixels = hit_pixels_q;
   assign bus.holdoff   = holdoff_q;
endmodule

// File: tb/tb_ball_obstacle_collision_detector.sv
// Directed bench: u0 uses a two-frame hold-off, u1 has no hold-off; both see the same pixel stream.
module tb_ball_obstacle_collision_detector;
   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        sof = 1'b0;
   logic [10:0] px = '0;
   logic [10:0] py = '0;
   logic        bdr = 1'b0;
   logic [3:0]  odr = '0;
`ifdef COLLISION_MASK_EN
   logic [3:0]  omask = 4'b1111;
`endif
   int tests = 0;
   int fails = 0;

   ball_obstacle_collision_detector_if #(.N_OBJ(4)) bus0 ();
   ball_obstacle_collision_detector_if #(.N_OBJ(4)) bus1 ();

   assign bus0.startOfFrame = sof;
   assign bus0.pixelX       = px;
   assign bus0.pixelY       = py;
   assign bus0.ballDR       = bdr;
   assign bus0.obstDR       = odr;
   assign bus1.startOfFrame = sof;
   assign bus1.pixelX       = px;
   assign bus1.pixelY       = py;
   assign bus1.ballDR       = bdr;
   assign bus1.obstDR       = odr;
`ifdef COLLISION_MASK_EN
   assign bus0.obstMask     = omask;
   assign bus1.obstMask     = omask;
`endif

   ball_obstacle_collision_detector #(.N_OBJ(4), .HOLDOFF_FRAMES(2)) u0 (
      .clk(clk), .resetN(resetN), .bus(bus0.slave));
   ball_obstacle_collision_detector #(.N_OBJ(4), .HOLDOFF_FRAMES(0)) u1 (
      .clk(clk), .resetN(resetN), .bus(bus1.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one pixel cycle, then sample just after the edge.
   task automatic cyc(input logic s, input int x, input int y, input logic b, input logic [3:0] o);
      sof = s;
      px  = 11'(x);
      py  = 11'(y);
      bdr = b;
      odr = o;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      repeat (3) cyc(0, 0, 0, 0, 4'b0000);
      chk("rst_collision", 32'(bus0.collision), 0);
      chk("rst_hitIndex",  32'(bus0.hitIndex), 0);
      chk("rst_hitX",      32'(bus0.hitX), 0);
      chk("rst_hitY",      32'(bus0.hitY), 0);
      chk("rst_hitPixels", 32'(bus0.hitPixels), 0);
      chk("rst_holdoff",   32'(bus0.holdoff), 0);
      resetN = 1'b1;

      // Partial frame after reset is discarded
      cyc(0, 100, 50, 1, 4'b0100);
      cyc(0, 101, 50, 1, 4'b0100);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("sync_no_collision", 32'(bus0.collision), 0);

      // Main report: first overlap on obstacles 1 and 2, then nine on obstacle 0
      cyc(0, 199, 300, 1, 4'b0000);
      cyc(0, 200, 300, 1, 4'b0110);
      for (int i = 0; i < 9; i++) cyc(0, 201 + i, 300, 1, 4'b0001);
      cyc(0, 210, 300, 0, 4'b0001);
      cyc(1, 210, 300, 1, 4'b0001);
      chk("rep_collision", 32'(bus0.collision), 1);
      chk("rep_hitIndex",  32'(bus0.hitIndex), 1);
      chk("rep_hitX",      32'(bus0.hitX), 200);
      chk("rep_hitY",      32'(bus0.hitY), 300);
      chk("rep_hitPixels", 32'(bus0.hitPixels), 10);
      chk("rep_holdoff",   32'(bus0.holdoff), 1);
      chk("h0_rep_collision", 32'(bus1.collision), 1);
      chk("h0_rep_holdoff",   32'(bus1.holdoff), 0);
      cyc(0, 0, 0, 0, 4'b0000);
      chk("rep_pulse_end", 32'(bus0.collision), 0);
      chk("rep_holdoff_held", 32'(bus0.holdoff), 1);
      chk("rep_hitX_held", 32'(bus0.hitX), 200);

      // Hold-off frame 1
      cyc(0, 5, 6, 1, 4'b1000);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("ho1_collision", 32'(bus0.collision), 0);
      chk("ho1_holdoff",   32'(bus0.holdoff), 1);
      chk("h0_f1_collision", 32'(bus1.collision), 1);
      chk("h0_f1_hitIndex",  32'(bus1.hitIndex), 3);
      chk("h0_f1_holdoff",   32'(bus1.holdoff), 0);
      // Hold-off frame 2: holdoff drops at its closing startOfFrame
      cyc(0, 5, 6, 1, 4'b1000);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("ho2_collision", 32'(bus0.collision), 0);
      chk("ho2_holdoff",   32'(bus0.holdoff), 0);
      chk("h0_f2_collision", 32'(bus1.collision), 1);
      // Third frame is collected again
      cyc(0, 7, 8, 1, 4'b0001);
      cyc(0, 8, 8, 1, 4'b0011);
      cyc(0, 9, 8, 1, 4'b1000);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("f3_collision", 32'(bus0.collision), 1);
      chk("f3_hitIndex",  32'(bus0.hitIndex), 0);
      chk("f3_hitX",      32'(bus0.hitX), 7);
      chk("f3_hitY",      32'(bus0.hitY), 8);
      chk("f3_hitPixels", 32'(bus0.hitPixels), 3);
      chk("f3_holdoff",   32'(bus0.holdoff), 1);
      chk("h0_f3_collision", 32'(bus1.collision), 1);
      chk("h0_f3_hitPixels", 32'(bus1.hitPixels), 3);

      // Overlap on the frame-boundary cycle alone is not reported
      cyc(1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 1, 4'b0001);
      chk("h0_sof_overlap_ignored", 32'(bus1.collision), 0);
      chk("armed_again_holdoff", 32'(bus0.holdoff), 0);

      // Saturating overlap count
      for (int i = 0; i < 70000; i++) cyc(0, 1 + (i % 600), 2, 1, 4'b0010);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("sat_collision", 32'(bus0.collision), 1);
      chk("sat_hitPixels", 32'(bus0.hitPixels), 32'hFFFF);
      chk("sat_hitX",      32'(bus0.hitX), 1);
      chk("sat_hitIndex",  32'(bus0.hitIndex), 1);

      // Mid-frame reset drops the pending report
      cyc(1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 4'b0000);
      cyc(0, 30, 40, 1, 4'b0100);
      cyc(0, 31, 40, 1, 4'b0100);
      #2 resetN = 1'b0;
      #1;
      chk("mid_rst_hitPixels", 32'(bus0.hitPixels), 0);
      chk("mid_rst_hitX",      32'(bus0.hitX), 0);
      chk("mid_rst_hitIndex",  32'(bus0.hitIndex), 0);
      chk("mid_rst_holdoff",   32'(bus0.holdoff), 0);
      chk("mid_rst_collision", 32'(bus0.collision), 0);
      cyc(0, 32, 40, 1, 4'b0100);
      resetN = 1'b1;
      cyc(0, 33, 40, 1, 4'b0100);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("post_rst_no_report", 32'(bus0.collision), 0);
      chk("post_rst_hitPixels", 32'(bus0.hitPixels), 0);

`ifdef COLLISION_MASK_EN
      // Obstacle 2 masked for one frame, then unmasked
      omask = 4'b1011;
      cyc(1, 0, 0, 0, 4'b0000);
      cyc(0, 60, 70, 1, 4'b0100);
      cyc(0, 61, 70, 1, 4'b0100);
      omask = 4'b1111;
      cyc(1, 0, 0, 0, 4'b0000);
      chk("mask_no_collision", 32'(bus0.collision), 0);
      cyc(0, 62, 71, 1, 4'b0100);
      cyc(1, 0, 0, 0, 4'b0000);
      chk("unmask_collision", 32'(bus0.collision), 1);
      chk("unmask_hitIndex",  32'(bus0.hitIndex), 2);
      chk("unmask_hitX",      32'(bus0.hitX), 62);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
